// File: rtl/t_ff_toggle_sched.sv
// Round-robin scheduler granting toggle bursts on an 8-bit T flip-flop bank.
// Four requesters each ask for n toggles on one bank bit; one burst runs at a time.
module t_ff_toggle_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] req_idx,
  input  logic [15:0] req_cnt,
  input  logic        clr,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [7:0]  q,
  output logic        busy
);

  localparam int unsigned REQ_W  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BANK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TOGGLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q,   ptr_d;
  logic [PTR_W-1:0]    w_q,     w_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [BANK_W-1:0]   q_q,     q_d;
  logic [REQ_W-1:0]    gnt_q,   gnt_d;
  logic [REQ_W-1:0]    done_q,  done_d;
  logic                busy_q,  busy_d;

  logic                win_found_c;
  logic [PTR_W-1:0]    win_id_c;

  // Round-robin search starting at ptr; first requester found wins.
  always_comb begin
    win_found_c = 1'b0;
    win_id_c    = ptr_q;
    for (int k = 0; k < int'(REQ_W); k++) begin
      if (!win_found_c && req[PTR_W'(ptr_q + PTR_W'(k))]) begin
        win_found_c = 1'b1;
        win_id_c    = PTR_W'(ptr_q + PTR_W'(k));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    gnt_d   = '0;
    done_d  = '0;
    busy_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found_c) begin
          w_d     = win_id_c;
          idx_d   = req_idx[IDX_W*32'(win_id_c) +: IDX_W];
          cnt_d   = req_cnt[CNT_W*32'(win_id_c) +: CNT_W];
          state_d = (cnt_d != '0) ? ST_TOGGLE : ST_DONE;
        end
      end
      ST_TOGGLE: begin
        if (!clr) begin
          q_d[idx_q] = ~q_q[idx_q];
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = w_q + PTR_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear wins over any toggle on the same edge.
    if (clr) begin
      q_d = '0;
    end

    // Outputs are registered against the state being entered.
    busy_d = (state_d != ST_IDLE);
    if (state_d != ST_IDLE) begin
      gnt_d = REQ_W'(1) << w_d;
    end
    if (state_d == ST_DONE) begin
      done_d = REQ_W'(1) << w_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign q    = q_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_t_ff_toggle_sched.sv
// Directed bench for t_ff_toggle_sched with hand-computed expectations.
module tb_t_ff_toggle_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_idx;
  logic [15:0] req_cnt;
  logic        clr;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  q;
  logic        busy;

  int n_chk;
  int n_fail;

  t_ff_toggle_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_idx (req_idx),
    .req_cnt (req_cnt),
    .clr     (clr),
    .gnt     (gnt),
    .done    (done),
    .q       (q),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_q",    16'(q),    16'h0);
    chk("rst_gnt",  16'(gnt),  16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_q;
    logic [3:0] exp_w;
    clk     = 1'b0;
    rst_n   = 1'b0;
    req     = '0;
    req_idx = '0;
    req_cnt = '0;
    clr     = 1'b0;
    n_chk   = 0;
    n_fail  = 0;
    #12;
    do_reset();

    // Single burst: requester 0, bit 3, five toggles
    tick();
    chk("idle_q", 16'(q), 16'h0);
    req     = 4'b0001;
    req_idx = 12'd3;
    req_cnt = 16'd5;
    tick();
    chk("s_gnt0",  16'(gnt),  16'h1);
    chk("s_busy0", 16'(busy), 16'h1);
    chk("s_q0",    16'(q),    16'h0);
    req = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("s_q",   16'(q),   (k % 2 == 1) ? 16'h08 : 16'h00);
      chk("s_gnt", 16'(gnt), 16'h1);
      chk("s_done", 16'(done), (k == 5) ? 16'h1 : 16'h0);
    end
    tick();
    chk("s_end_gnt",  16'(gnt),  16'h0);
    chk("s_end_done", 16'(done), 16'h0);
    chk("s_end_busy", 16'(busy), 16'h0);
    chk("s_end_q",    16'(q),    16'h08);

    // Round robin with all requesters held high
    do_reset();
    req     = 4'b1111;
    req_idx = 12'b011_010_001_000;
    req_cnt = 16'h1111;
    exp_q   = 8'h00;
    for (int i = 0; i < 5; i++) begin
      exp_w = 4'b0001 << (i % 4);
      exp_q = exp_q ^ {4'b0000, exp_w};
      tick();
      chk("rr_gnt",  16'(gnt),  16'(exp_w));
      chk("rr_done0", 16'(done), 16'h0);
      tick();
      chk("rr_done", 16'(done), 16'(exp_w));
      chk("rr_q",    16'(q),    16'(exp_q));
      tick();
      chk("rr_idle_done", 16'(done), 16'h0);
      chk("rr_idle_busy", 16'(busy), 16'h0);
      if (i == 3) chk("rr_q4", 16'(q), 16'h0F);
    end

    // Zero count on requester 2; pointer sits at 1 after the last grant to 0
    req     = 4'b0100;
    req_cnt = 16'h1011;
    tick();
    chk("z_gnt",  16'(gnt),  16'h4);
    chk("z_done", 16'(done), 16'h4);
    chk("z_q",    16'(q),    16'h0E);
    req = '0;
    tick();
    chk("z_gnt_off", 16'(gnt), 16'h0);
    chk("z_q_end",   16'(q),   16'h0E);

    // Clear on the second toggle edge of a four-toggle burst
    do_reset();
    req     = 4'b0001;
    req_idx = 12'd0;
    req_cnt = 16'd4;
    tick();
    req = '0;
    tick();
    chk("c_t1", 16'(q), 16'h01);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("c_t2", 16'(q), 16'h00);
    tick();
    chk("c_t3", 16'(q), 16'h01);
    tick();
    chk("c_t4",   16'(q),    16'h00);
    chk("c_done", 16'(done), 16'h1);

    // Async reset mid-burst on requester 1, bit 5
    do_reset();
    req     = 4'b0010;
    req_idx = 12'(5) << 3;
    req_cnt = 16'(6) << 4;
    tick();
    chk("a_gnt", 16'(gnt), 16'h2);
    tick();
    tick();
    tick();
    chk("a_q", 16'(q), 16'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_rst_q",    16'(q),    16'h0);
    chk("a_rst_gnt",  16'(gnt),  16'h0);
    chk("a_rst_busy", 16'(busy), 16'h0);
    tick();
    chk("a_rst_done", 16'(done), 16'h0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Inputs change mid-burst; latched bit 2 still gets all three toggles
    do_reset();
    req     = 4'b0001;
    req_idx = 12'd2;
    req_cnt = 16'd3;
    tick();
    req     = '0;
    req_idx = 12'd7;
    req_cnt = 16'hFFFF;
    tick();
    chk("m_t1", 16'(q), 16'h04);
    tick();
    chk("m_t2", 16'(q), 16'h00);
    tick();
    chk("m_t3",   16'(q),    16'h04);
    chk("m_done", 16'(done), 16'h1);
    chk("m_gnt",  16'(gnt),  16'h1);
    tick();
    chk("m_end_q",    16'(q),    16'h04);
    chk("m_end_busy", 16'(busy), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/t_ff_toggle_sched.md
T_FF_TOGGLE_SCHED -- requirements
Module: t_ff_toggle_sched

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising-edge.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req  input  4  per-requester toggle-burst request, level; bit i = requester i.
REQ-004 SHALL have ports: req_idx  input  12  target bit in bank; requester i uses [3i+2:3i].
REQ-005 SHALL have ports: req_cnt  input  16  toggle count 0-15; requester i uses [4i+3:4i].
REQ-006 SHALL have ports: clr  input  1  synchronous clear of bank.
REQ-007 SHALL have ports: gnt  output  4  one-hot grant, high for whole burst.
REQ-008 SHALL have ports: done  output  4  one-hot, one-cycle burst-complete pulse.
REQ-009 SHALL have ports: q  output  8  T flip-flop bank state.
REQ-010 SHALL have ports: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have one clock (clk); reset SHALL be asynchronous, active-low (rst_n).

Function
REQ-012 SHALL implement an 8-bit bank of T flip-flops; a bit changes only when toggled by the scheduler or cleared by clr.
REQ-013 SHALL implement FSM states IDLE, TOGGLE, DONE.
REQ-014 IDLE: on an edge with any req bit high, SHALL select winner w by round-robin, latch w, req_idx[w], req_cnt[w]; next state TOGGLE if cnt!=0, DONE if cnt==0.
REQ-015 Round-robin: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); ptr reset value 0; on leaving DONE, ptr SHALL become w+1 mod 4.
REQ-016 TOGGLE: each edge SHALL invert q[idx] and decrement the latched count; the edge on which count is 1 SHALL perform the last toggle and move to DONE.
REQ-017 A burst of n (1-15) SHALL produce exactly n toggles on n consecutive edges; no toggle of any other bit.
REQ-018 gnt[w] SHALL be high from the cycle after the winning IDLE edge through the DONE cycle inclusive; all other gnt bits low.
REQ-019 DONE: done[w] SHALL be high for exactly one cycle; next edge SHALL return to IDLE.
REQ-020 Latched w/idx/cnt SHALL NOT change during a burst; changes on req, req_idx, req_cnt mid-burst SHALL be ignored.
REQ-021 Deassertion of req[w] mid-burst SHALL NOT abort the burst.
REQ-022 A req still high in IDLE after done SHALL be treated as a new request, arbitrated normally.
REQ-023 clr high on an edge SHALL set q to 0 and suppress any toggle on that edge; count SHALL still decrement and FSM SHALL advance normally.
REQ-024 Minimum spacing between consecutive bursts SHALL be one IDLE cycle; throughput for count n is n+2 cycles per burst.
REQ-025 busy SHALL be low only in IDLE.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, q=0, gnt=0, done=0, busy=0, ptr=0, latched count=0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no done pulse; q SHALL read 0.
REQ-028 After rst_n rises, first arbitration SHALL occur on the first clk edge with req nonzero.

Verification
REQ-029 Single: req=0001, idx0=3, cnt0=5 -> gnt=0001 for 6 cycles, q[3] toggles 5 times ending 1, done=0001 one cycle, q others 0.
REQ-030 Round-robin: req=1111 held, all cnt=1, idx_i=i -> grants in order 0,1,2,3,0; each done one cycle; q=0000_1111 after four bursts.
REQ-031 Zero count: req=0100, cnt2=0 -> IDLE->DONE, done=0100, gnt=0100 one cycle, q unchanged.
REQ-032 clr mid-burst: cnt=4 on bit 0, clr high on 2nd toggle edge -> q[0]=0 after that edge, then toggles 3rd,4th -> q[0]=0, done pulses.
REQ-033 Async reset mid-burst: rst_n low between edges during TOGGLE -> q, gnt, busy go 0 without waiting for clk; no done pulse.
REQ-034 Mid-burst input change: change req_idx[w] and drop req[w] during TOGGLE -> original bit receives full count, done still asserted.
